// File: rtl/exp_table_loader.sv
`default_nettype none
// ============================================================================
// exp_table_loader
// Streams a 2*NUM_IDX entry {base, offset} table into the exp MAC config port.
// Rev 1.0 - initial release
// ============================================================================
module exp_table_loader #(
    parameter int BASE_WIDTH   = 16,
    parameter int OFFSET_WIDTH = 16,
    parameter int NUM_IDX      = 13
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [BASE_WIDTH+OFFSET_WIDTH-1:0] in_data,
    input  logic                              in_last,
    output logic                              cfg_w_en,
    output logic                              cfg_sgn,
    output logic [3:0]                        cfg_idx,
    output logic [BASE_WIDTH-1:0]             cfg_base,
    output logic [OFFSET_WIDTH-1:0]           cfg_offset,
    output logic                              busy,
    output logic                              done,
    output logic                              err,
    output logic                              table_valid
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_IDX - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t     state;
    logic       cnt_sgn;
    logic [3:0] cnt_idx;
    logic       finish_pend;
    logic       finish_ok;
    logic       accept;
    logic       last_entry;

    assign accept     = in_valid && in_ready;
    assign last_entry = cnt_sgn && (cnt_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt_sgn     <= 1'b0;
            cnt_idx     <= 4'd0;
            finish_pend <= 1'b0;
            finish_ok   <= 1'b0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            cfg_w_en    <= 1'b0;
            cfg_sgn     <= 1'b0;
            cfg_idx     <= 4'd0;
            cfg_base    <= '0;
            cfg_offset  <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            table_valid <= 1'b0;
        end else begin
            cfg_w_en    <= 1'b0;
            done        <= 1'b0;
            finish_pend <= 1'b0;

            // Status lands one edge after the terminating word, once the MAC holds it.
            if (finish_pend) begin
                done        <= 1'b1;
                err         <= !finish_ok;
                table_valid <= finish_ok;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= LOAD;
                        in_ready    <= 1'b1;
                        busy        <= 1'b1;
                        err         <= 1'b0;
                        table_valid <= 1'b0;
                        cnt_sgn     <= 1'b0;
                        cnt_idx     <= 4'd0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        cfg_w_en   <= 1'b1;
                        cfg_sgn    <= cnt_sgn;
                        cfg_idx    <= cnt_idx;
                        cfg_base   <= in_data[BASE_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
                        cfg_offset <= in_data[OFFSET_WIDTH-1:0];
                        if (in_last || last_entry) begin
                            state       <= IDLE;
                            in_ready    <= 1'b0;
                            busy        <= 1'b0;
                            finish_pend <= 1'b1;
                            finish_ok   <= in_last && last_entry;
                        end else if (cnt_idx == LAST_IDX) begin
                            cnt_idx <= 4'd0;
                            cnt_sgn <= 1'b1;
                        end else begin
                            cnt_idx <= cnt_idx + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exp_table_loader.sv
`default_nettype none
// ============================================================================
// tb_exp_table_loader
// Randomized stimulus checked every cycle against a behavioural table-load model.
// Rev 1.0 - initial release
// ============================================================================
module tb_exp_table_loader;

    localparam int NI = 13;
    localparam int NE = 2 * NI;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        cfg_w_en;
    logic        cfg_sgn;
    logic [3:0]  cfg_idx;
    logic [15:0] cfg_base;
    logic [15:0] cfg_offset;
    logic        busy;
    logic        done;
    logic        err;
    logic        table_valid;

    int checks = 0;
    int errors = 0;

    exp_table_loader #(.BASE_WIDTH(16), .OFFSET_WIDTH(16), .NUM_IDX(NI)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .cfg_w_en(cfg_w_en), .cfg_sgn(cfg_sgn), .cfg_idx(cfg_idx),
        .cfg_base(cfg_base), .cfg_offset(cfg_offset), .busy(busy),
        .done(done), .err(err), .table_valid(table_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: expected outputs for the current cycle, plus load progress.
    bit          m_loading = 0;
    int          m_n = 0;
    bit          m_pend = 0;
    bit          m_ok = 0;
    bit          e_we = 0;
    bit          e_sgn = 0;
    logic [3:0]  e_idx = '0;
    logic [15:0] e_base = '0;
    logic [15:0] e_off = '0;
    bit          e_done = 0;
    bit          e_err = 0;
    bit          e_tv = 0;

    always @(negedge rst_n) begin
        m_loading = 0; m_n = 0; m_pend = 0; m_ok = 0;
        e_we = 0; e_sgn = 0; e_idx = '0; e_base = '0; e_off = '0;
        e_done = 0; e_err = 0; e_tv = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            bit pend_now;
            bit ok_now;
            pend_now = m_pend;
            ok_now   = m_ok;
            e_we = 0; e_done = 0; m_pend = 0;
            if (pend_now) begin
                e_done = 1; e_err = !ok_now; e_tv = ok_now;
            end
            if (!m_loading) begin
                if (start) begin
                    m_loading = 1; m_n = 0; e_err = 0; e_tv = 0;
                end
            end else if (in_valid) begin
                e_we   = 1;
                e_sgn  = (m_n >= NI);
                e_idx  = 4'(m_n % NI);
                e_base = in_data[31:16];
                e_off  = in_data[15:0];
                if (in_last || m_n == NE - 1) begin
                    m_loading = 0; m_pend = 1; m_ok = in_last && (m_n == NE - 1);
                end
                m_n++;
            end
        end
    end

    int         wr_cnt = 0;
    int         done_cnt = 0;
    logic       last_sgn = 0;
    logic [3:0] last_idx = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("cfg_w_en", cfg_w_en, e_we);
            if (e_we) begin
                check("cfg_sgn", cfg_sgn, e_sgn);
                check("cfg_idx", cfg_idx, e_idx);
                check("cfg_base", cfg_base, e_base);
                check("cfg_offset", cfg_offset, e_off);
            end
            check("in_ready", in_ready, m_loading);
            check("busy", busy, m_loading);
            check("done", done, e_done);
            check("err", err, e_err);
            check("table_valid", table_valid, e_tv);
            if (cfg_w_en) begin
                wr_cnt++; last_sgn = cfg_sgn; last_idx = cfg_idx;
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) tick();
    endtask

    task automatic do_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic send(input logic [15:0] b, input logic [15:0] o, input bit last, input int gapmax);
        repeat ($urandom_range(gapmax, 0)) begin
            in_valid = 0;
            tick();
        end
        in_valid = 1; in_data = {b, o}; in_last = last;
        tick();
        in_valid = 0; in_last = 0;
    endtask

    task automatic clear_counts();
        wr_cnt = 0; done_cnt = 0;
    endtask

    task automatic full_load(input int gapmax);
        do_start();
        for (int n = 0; n < NE; n++)
            send(16'($urandom), 16'($urandom), n == NE - 1, gapmax);
        idle(3);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_ready", in_ready, 0);
        check("reset_tv", table_valid, 0);
        check("reset_err", err, 0);
        rst_n = 1;
        tick();

        // Nominal load
        clear_counts();
        do_start();
        for (int n = 0; n < NE; n++)
            send(16'(n + 'h100), 16'(n + 'h200), n == NE - 1, 0);
        idle(3);
        check("nom_writes", wr_cnt, 26);
        check("nom_done_cnt", done_cnt, 1);
        check("nom_last_sgn", last_sgn, 1);
        check("nom_last_idx", last_idx, 12);
        check("nom_tv", table_valid, 1);
        check("nom_err", err, 0);
        check("nom_last_base", cfg_base, 16'h119);

        // Backpressure gaps
        clear_counts();
        full_load(3);
        check("gap_writes", wr_cnt, 26);
        check("gap_tv", table_valid, 1);

        // Early in_last on entry 5
        clear_counts();
        do_start();
        for (int n = 0; n < 6; n++)
            send(16'($urandom), 16'($urandom), n == 5, 1);
        idle(3);
        check("early_writes", wr_cnt, 6);
        check("early_last_sgn", last_sgn, 0);
        check("early_last_idx", last_idx, 5);
        check("early_err", err, 1);
        check("early_tv", table_valid, 0);
        check("early_ready", in_ready, 0);
        check("early_done_cnt", done_cnt, 1);

        // Missing in_last, then a 27th word presented in IDLE
        clear_counts();
        do_start();
        for (int n = 0; n < NE; n++)
            send(16'($urandom), 16'($urandom), 0, 1);
        in_valid = 1; in_data = 32'hDEAD_BEEF;
        repeat (4) tick();
        in_valid = 0;
        idle(2);
        check("miss_writes", wr_cnt, 26);
        check("miss_err", err, 1);
        check("miss_tv", table_valid, 0);

        // Reset mid-load after entry 10
        clear_counts();
        do_start();
        for (int n = 0; n < 11; n++)
            send(16'($urandom), 16'($urandom), 0, 1);
        #2 rst_n = 0;
        #1;
        check("rst_w_en", cfg_w_en, 0);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_base", cfg_base, 0);
        check("rst_idx", cfg_idx, 0);
        #2 rst_n = 1;
        tick();
        idle(2);
        check("rst_tv", table_valid, 0);
        check("rst_ready_after", in_ready, 0);
        clear_counts();
        full_load(2);
        check("rst_reload_tv", table_valid, 1);
        check("rst_reload_writes", wr_cnt, 26);

        // Start during LOAD is ignored
        do_start();
        for (int n = 0; n < NE; n++) begin
            if (n == 3) start = 1;
            send(16'($urandom), 16'($urandom), n == NE - 1, 0);
            start = 0;
        end
        idle(3);
        check("ign_start_tv", table_valid, 1);

        // Errored load, restart on its done cycle
        do_start();
        for (int n = 0; n < 4; n++)
            send(16'($urandom), 16'($urandom), n == 3, 0);
        tick();
        check("restart_done", done, 1);
        check("restart_err_before", err, 1);
        do_start();
        check("restart_err_cleared", err, 0);
        check("restart_busy", busy, 1);
        clear_counts();
        for (int n = 0; n < NE; n++)
            send(16'($urandom), 16'($urandom), n == NE - 1, 2);
        idle(3);
        check("restart_tv", table_valid, 1);
        check("restart_writes", wr_cnt, 26);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
